// File: rtl/seq_gen_if.sv
// Control/stream bundle for seq_gen: pattern loading, playback handshake and symbol output.
interface seq_gen_if #(
  parameter int GAP_W = 4,
  parameter int CNT_W = 4
);
  logic             Wr_en;
  logic [1:0]       Wr_sym;
  logic             Clr;
  logic             Start;
  logic             Stop;
  logic             Repeat;
  logic [GAP_W-1:0] Gap;
  logic [1:0]       Dout;
  logic             Dvalid;
  logic             Busy;
  logic             Done;
  logic [CNT_W-1:0] Count;
  logic             Full;

  modport master (
    output Wr_en, Wr_sym, Clr, Start, Stop, Repeat, Gap,
    input  Dout, Dvalid, Busy, Done, Count, Full
  );

  modport slave (
    input  Wr_en, Wr_sym, Clr, Start, Stop, Repeat, Gap,
    output Dout, Dvalid, Busy, Done, Count, Full
  );
endinterface

// File: rtl/seq_gen.sv
// Programmable 2-bit symbol pattern player with per-symbol hold, repeat and start/stop/done.
module seq_gen #(
  parameter int DEPTH = 8,
  parameter int GAP_W = 4,
  parameter int CNT_W = 4
) (
  input  logic      Clk,
  input  logic      Reset,
  seq_gen_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_PLAY} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0] hold_q, hold_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       mem_q [DEPTH];
  logic             wr_fire;
  logic             full;
  logic             last_sym;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign last_sym = (idx_q == cnt_q - CNT_W'(1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    wr_fire = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!bus.Stop) begin
          if (bus.Clr) begin
            cnt_d = '0;
          end else if (bus.Start && (cnt_q != '0)) begin
            state_d = S_PLAY;
            idx_d   = '0;
            hold_d  = bus.Gap;
            gap_d   = bus.Gap;
          end else if (bus.Wr_en && !full) begin
            wr_fire = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      S_PLAY: begin
        if (bus.Stop) begin
          state_d = S_IDLE;
        end else if (hold_q != '0) begin
          hold_d = hold_q - GAP_W'(1);
        end else begin
          hold_d = gap_q;
          if (!last_sym) begin
            idx_d = idx_q + CNT_W'(1);
          end else if (bus.Repeat) begin
            idx_d = '0;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Output registers are loaded from the next-state view so a symbol appears right after its edge.
    dvalid_d = (state_d == S_PLAY);
    busy_d   = (state_d == S_PLAY);
    dout_d   = (state_d == S_PLAY) ? mem_q[idx_d[IDX_W-1:0]] : 2'b00;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      hold_q   <= '0;
      gap_q    <= '0;
      cnt_q    <= '0;
      dout_q   <= 2'b00;
      dvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      gap_q    <= gap_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Pattern storage is deliberately not reset; Count=0 makes it unreachable.
  always_ff @(posedge Clk) begin
    if (wr_fire) mem_q[cnt_q[IDX_W-1:0]] <= bus.Wr_sym;
  end

  assign bus.Dout   = dout_q;
  assign bus.Dvalid = dvalid_q;
  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;
  assign bus.Count  = cnt_q;
  assign bus.Full   = full;
endmodule

// File: tb/tb_seq_gen.sv
// Directed self-checking bench for seq_gen: reset, single pass, hold, full, repeat/stop, ignored requests.
module tb_seq_gen;
  logic clk;
  logic rst_n;
  int unsigned checks;
  int unsigned errors;

  seq_gen_if #(.GAP_W(4), .CNT_W(4)) bus ();

  seq_gen #(.DEPTH(8), .GAP_W(4), .CNT_W(4)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Wr_en  = 1'b0;
    bus.Wr_sym = 2'b00;
    bus.Clr    = 1'b0;
    bus.Start  = 1'b0;
    bus.Stop   = 1'b0;
  endtask

  task automatic write_sym(input logic [1:0] s);
    bus.Wr_en  = 1'b1;
    bus.Wr_sym = s;
    tick();
    bus.Wr_en  = 1'b0;
  endtask

  task automatic clear_pat();
    bus.Clr = 1'b1;
    tick();
    bus.Clr = 1'b0;
  endtask

  task automatic start_play();
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
  endtask

  task automatic expect_sym(input string tag, input logic [1:0] s);
    chk({tag, "_dvalid"}, 32'(bus.Dvalid), 1);
    chk({tag, "_dout"}, 32'(bus.Dout), 32'(s));
    chk({tag, "_busy"}, 32'(bus.Busy), 1);
    tick();
  endtask

  task automatic expect_done(input string tag);
    chk({tag, "_dvalid"}, 32'(bus.Dvalid), 0);
    chk({tag, "_dout"}, 32'(bus.Dout), 0);
    chk({tag, "_busy"}, 32'(bus.Busy), 0);
    chk({tag, "_done"}, 32'(bus.Done), 1);
    tick();
    chk({tag, "_done_off"}, 32'(bus.Done), 0);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_dout"}, 32'(bus.Dout), 0);
    chk({tag, "_dvalid"}, 32'(bus.Dvalid), 0);
    chk({tag, "_busy"}, 32'(bus.Busy), 0);
    chk({tag, "_done"}, 32'(bus.Done), 0);
    chk({tag, "_count"}, 32'(bus.Count), 0);
    chk({tag, "_full"}, 32'(bus.Full), 0);
  endtask

  logic [1:0] pat4 [9];
  logic [1:0] exp3 [3];

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    idle_inputs();
    bus.Repeat = 1'b0;
    bus.Gap    = '0;
    pat4 = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
    exp3 = '{2'b01, 2'b10, 2'b11};

    // 1. reset with random inputs toggling across edges
    #2 rst_n = 1'b0;
    #1 check_reset_outs("rst_async");
    for (int i = 0; i < 3; i++) begin
      bus.Wr_en  = 1'($urandom);
      bus.Wr_sym = 2'($urandom);
      bus.Clr    = 1'($urandom);
      bus.Start  = 1'($urandom);
      bus.Stop   = 1'($urandom);
      bus.Repeat = 1'($urandom);
      bus.Gap    = 4'($urandom);
      tick();
    end
    check_reset_outs("rst_held");
    idle_inputs();
    bus.Repeat = 1'b0;
    bus.Gap    = '0;
    rst_n = 1'b1;
    tick();
    start_play();
    chk("start_empty_busy", 32'(bus.Busy), 0);
    chk("start_empty_dvalid", 32'(bus.Dvalid), 0);

    // 2. single pass, no gap
    for (int i = 0; i < 3; i++) write_sym(exp3[i]);
    chk("load3_count", 32'(bus.Count), 3);
    start_play();
    for (int i = 0; i < 3; i++) expect_sym("pass0", exp3[i]);
    expect_done("pass0_end");

    // 3. hold of Gap+1 cycles; Gap change mid-play ignored
    bus.Gap = 4'd2;
    start_play();
    bus.Gap = 4'd0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) expect_sym("gap2", exp3[i]);
    expect_done("gap2_end");

    // 4. full boundary
    clear_pat();
    chk("clr_count", 32'(bus.Count), 0);
    for (int i = 0; i < 9; i++) begin
      write_sym(pat4[i]);
      if (i == 6) chk("seven_full", 32'(bus.Full), 0);
      if (i == 7) chk("eight_full", 32'(bus.Full), 1);
    end
    chk("ninth_count", 32'(bus.Count), 8);
    chk("ninth_full", 32'(bus.Full), 1);
    start_play();
    for (int i = 0; i < 8; i++) expect_sym("full_play", pat4[i]);
    expect_done("full_end");

    // 5a. repeat, then drop Repeat mid-pass
    clear_pat();
    write_sym(2'b10);
    write_sym(2'b01);
    bus.Repeat = 1'b1;
    start_play();
    expect_sym("rep_a", 2'b10);
    expect_sym("rep_b", 2'b01);
    expect_sym("rep_c", 2'b10);
    expect_sym("rep_d", 2'b01);
    bus.Repeat = 1'b0;
    expect_sym("rep_e", 2'b10);
    expect_sym("rep_f", 2'b01);
    expect_done("rep_end");

    // 5b. Stop on the final cycle of the last symbol
    bus.Gap = 4'd1;
    start_play();
    expect_sym("stop_a", 2'b10);
    expect_sym("stop_b", 2'b10);
    expect_sym("stop_c", 2'b01);
    bus.Stop = 1'b1;
    chk("stop_last_dout", 32'(bus.Dout), 32'(2'b01));
    tick();
    bus.Stop = 1'b0;
    chk("stop_dvalid", 32'(bus.Dvalid), 0);
    chk("stop_busy", 32'(bus.Busy), 0);
    chk("stop_done", 32'(bus.Done), 0);
    tick();
    chk("stop_done_later", 32'(bus.Done), 0);

    // 6. requests ignored during play, then reset mid-play
    bus.Gap    = 4'd0;
    bus.Repeat = 1'b1;
    start_play();
    chk("ign_first", 32'(bus.Dout), 32'(2'b10));
    bus.Wr_en  = 1'b1;
    bus.Wr_sym = 2'b11;
    bus.Clr    = 1'b1;
    bus.Start  = 1'b1;
    tick();
    chk("ign_count1", 32'(bus.Count), 2);
    expect_sym("ign_a", 2'b01);
    chk("ign_count2", 32'(bus.Count), 2);
    expect_sym("ign_b", 2'b10);
    idle_inputs();
    expect_sym("ign_c", 2'b01);
    #2 rst_n = 1'b0;
    #1 check_reset_outs("rst_mid");
    rst_n = 1'b1;
    tick();
    start_play();
    chk("post_rst_busy", 32'(bus.Busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_gen.md
Name: seq_gen

Overview:
- Stimulus transmitter for the 2-bit symbol detectors.
- Stores a programmable pattern of 2-bit symbols and plays it out as a registered `Dout`/`Dvalid` stream, suitable for driving a detector's `Din` directly.
- Supports single-pass or repeating playback, a per-symbol hold (gap) count, and a start/stop/done handshake.

Parameters:
- DEPTH, 8, maximum number of stored symbols (≥2).
- GAP_W, 4, width of the per-symbol hold count.
- CNT_W, 4, width of `Count`; must satisfy 2^CNT_W > DEPTH.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Wr_en  input  1  append `Wr_sym` to the pattern (IDLE only).
- Wr_sym  input  2  symbol to append.
- Clr  input  1  empty the pattern (IDLE only).
- Start  input  1  begin playback.
- Stop  input  1  abort playback.
- Repeat  input  1  loop the pattern; sampled at the end of each pass.
- Gap  input  GAP_W  each symbol is held for Gap+1 cycles; sampled on Start.
- Dout  output  2  current symbol; 2'b00 when `Dvalid`=0.
- Dvalid  output  1  `Dout` carries a pattern symbol.
- Busy  output  1  playback in progress.
- Done  output  1  one-cycle pulse at normal end of playback.
- Count  output  CNT_W  number of stored symbols.
- Full  output  1  `Count`==DEPTH.

Behaviour:
- **Reset (Reset=0, asynchronous):**
  - State=IDLE; `Dout`=00, `Dvalid`=0, `Busy`=0, `Done`=0, `Count`=0, `Full`=0.
  - Index and hold counters are 0.
  - Memory contents are not cleared; they are unreachable while `Count`=0.
- **All outputs are registered.**
- **States:** IDLE, PLAY.
- **IDLE:**
  - `Start`=1 and `Count`>0: load hold counter from `Gap`, set index=0, enter PLAY. After that same edge, `Dout`=mem[0], `Dvalid`=1, `Busy`=1. Latency is 0 cycles from the sampling edge.
  - `Start` with `Count`=0 is ignored.
  - `Wr_en`=1 and `Full`=0: mem[Count] <= `Wr_sym`, `Count`++.
  - `Wr_en` while `Full` is ignored and `Count` is unchanged.
  - `Clr`=1: `Count` <= 0.
  - Priority in IDLE: `Stop` > `Clr` > `Start` > `Wr_en`. Only the highest-priority request acts; the others are dropped (no queuing).
- **PLAY:**
  - Each symbol stays on `Dout` for Gap+1 consecutive cycles; the hold counter counts down to 0.
  - Hold expires on index < `Count`-1: index++, next symbol appears with no bubble.
  - Hold expires on the last index, `Repeat`=1: index <= 0, mem[0] follows with no bubble.
  - Hold expires on the last index, `Repeat`=0: return to IDLE. In the next cycle `Dvalid`=0, `Dout`=00, `Busy`=0, `Done`=1 for exactly one cycle.
  - `Stop`=1: return to IDLE at that edge. `Dvalid`=0 and `Busy`=0 in the next cycle; `Done` is not asserted. `Stop` wins over a simultaneous end-of-pass.
  - `Start`, `Wr_en` and `Clr` are ignored; `Count` and memory are frozen.
  - `Gap` changes during PLAY have no effect until the next Start.
- **Done:** asserted only in the single cycle after a normal pass end; 0 otherwise.
- **Full:** combinational compare of `Count` against DEPTH, driven from the registered `Count`.
- **Reset mid-PLAY:** outputs go to reset values immediately (asynchronous). `Count`=0, so the pattern must be reloaded.

Test Plan:
1. **Reset:** assert Reset=0 with random inputs -> `Dout`=00, `Dvalid`=0, `Busy`=0, `Done`=0, `Count`=0, `Full`=0; Start after release with `Count`=0 -> no playback.
2. **Single pass, no gap:** load 01,10,11 with `Gap`=0, `Repeat`=0, pulse Start -> `Dout`=01,10,11 on 3 consecutive cycles with `Dvalid`=1, `Busy`=1; next cycle `Dvalid`=0, `Done`=1 (1 cycle), `Busy`=0.
3. **Hold count:** same pattern with `Gap`=2 -> each symbol held 3 cycles (9 valid cycles total), then `Done` pulse; changing `Gap` mid-play has no effect.
4. **Full boundary (DEPTH=8):** write 9 symbols 00,01,10,11,00,01,10,11,11 -> `Full`=1 after the 8th, `Count`=8, 9th ignored; playback shows exactly the first 8.
5. **Repeat and Stop:**
   - `Repeat`=1 with pattern 10,01 -> 10,01,10,01… with no gaps.
   - Drop `Repeat` mid-pass -> the current pass completes, then `Done`.
   - Separate run: `Stop` asserted on the last symbol's final cycle -> `Dvalid`=0 next cycle, no `Done`.
6. **Ignored requests and reset mid-play:**
   - `Wr_en`/`Clr`/`Start` during PLAY -> `Count` and stream unchanged.
   - Reset=0 mid-PLAY -> outputs reset asynchronously, `Count`=0.
